// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver state enum and
// a parity helper used by both the RX and TX sides.
package uart_pkg;

    // Parity mode encodings carried by the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Receiver frame states.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_e;

    // Returns 1 when the received parity bit disagrees with the data.
    // data_xor is the XOR-reduction of the data bits.
    // Odd parity requires an odd number of ones across data and parity bit;
    // even parity requires an even number.
    function automatic logic parity_mismatch(input int mode, input logic data_xor,
                                             input logic par_bit);
        logic err;
        err = 1'b0;
        if (mode == PAR_ODD) begin
            err = ~(data_xor ^ par_bit);
        end else if (mode == PAR_EVEN) begin
            err = data_xor ^ par_bit;
        end
        return err;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an asynchronous serial line. Resets to 1 so
// an idle-high line never looks like a start bit coming out of reset.
module uart_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic sck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    // Shift the async input through the flop chain; stage 0 is the capture flop.
    always_ff @(posedge sck) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with mid-bit sampling.
//
// Output handshake: data_valid is a one-cycle strobe with no ready/back-
// pressure. data_out, parity_err and frame_err change only in the strobe
// cycle and hold until the next strobe, so a consumer may sample them with
// data_valid or at any later time before the next strobe.
//
// Frame timing: the start bit is confirmed half a bit period after the
// falling edge is seen on rx_s; every later bit (data, parity, stop) is
// sampled one full bit period after the previous sample, i.e. mid-bit.
// The strobe comes one cycle after the last stop sample.
//
// A frame whose last stop sample is 0 disarms start detection until the
// line has been seen high, so a held break yields exactly one word.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 sck,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);

    // Parameter range checks at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
        $error("uart_rx_os: CLKS_PER_BIT must be even and >= 4");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_os: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("uart_rx_os: SYNC_STAGES must be >= 2");
    end

    // Synchronised line; every decision below uses rx_s only.
    logic rx_s;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .sck (sck),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame state and datapath registers.
    rx_state_e            state;
    logic [TICK_W-1:0]    tick_cnt;   // cycles since the last sample point
    logic [IDX_W-1:0]     bit_idx;    // data bit index in DATA, stop bit index in STOP
    logic [DATA_BITS-1:0] shift_reg;  // LSB-first deserialiser
    logic                 par_bad;    // parity mismatch seen in this frame
    logic                 stop_bad;   // some stop sample of this frame was 0
    logic                 stop_done;  // last stop bit sampled; deliver next cycle
    logic                 armed;      // start detection enabled

    // Single frame FSM: tick counting, sampling, deserialising and output registers.
    always_ff @(posedge sck) begin
        if (rst) begin
            state      <= RX_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            stop_done  <= 1'b0;
            armed      <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            case (state)
                RX_IDLE: begin
                    if (!armed) begin
                        // After a break, wait for the line to return high.
                        if (rx_s) begin
                            armed <= 1'b1;
                        end
                    end else if (!rx_s) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                RX_START: begin
                    if (tick_cnt == HALF_TICK) begin
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            state    <= RX_DATA;
                            bit_idx  <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end else begin
                            // Line high again at mid start bit: a glitch, drop it silently.
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (tick_cnt == FULL_TICK) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_DATA) begin
                            bit_idx   <= '0;
                            stop_done <= 1'b0;
                            state     <= (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                RX_PAR: begin
                    if (tick_cnt == FULL_TICK) begin
                        tick_cnt <= '0;
                        par_bad  <= parity_mismatch(PARITY, ^shift_reg, rx_s);
                        state    <= RX_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (stop_done) begin
                        // Deliver the word and its flags together.
                        data_out   <= shift_reg;
                        parity_err <= par_bad;
                        frame_err  <= stop_bad;
                        data_valid <= 1'b1;
                        stop_done  <= 1'b0;
                        state      <= RX_IDLE;
                        busy       <= 1'b0;
                    end else if (tick_cnt == FULL_TICK) begin
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            stop_bad <= 1'b1;
                        end
                        if (bit_idx == LAST_STOP) begin
                            stop_done <= 1'b1;
                            // Line still low at the final stop: treat as break.
                            if (!rx_s) begin
                                armed <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three configurations (8N1, 8E1, 9O2) driven with
// directed and random frames. Each frame pushes its expected word, flags
// and strobe cycle into a scoreboard; one compare process checks every
// cycle that strobes match the queue and that outputs hold between strobes.
module tb_uart_rx_os;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic sck = 1'b0;
  logic rst = 1'b1;
  always #5 sck = ~sck;

  int cyc = 0;
  always @(posedge sck) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       rx_a [3];
  logic [7:0] dout0, dout1;
  logic [8:0] dout2;
  logic       dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, busy0, busy1, busy2;

  logic [8:0] dout_a [3];
  logic       dv_a [3];
  logic       pe_a [3];
  logic       fe_a [3];
  logic       busy_a [3];

  assign dout_a[0] = {1'b0, dout0};
  assign dout_a[1] = {1'b0, dout1};
  assign dout_a[2] = dout2;
  assign dv_a[0] = dv0;
  assign dv_a[1] = dv1;
  assign dv_a[2] = dv2;
  assign pe_a[0] = pe0;
  assign pe_a[1] = pe1;
  assign pe_a[2] = pe2;
  assign fe_a[0] = fe0;
  assign fe_a[1] = fe1;
  assign fe_a[2] = fe2;
  assign busy_a[0] = busy0;
  assign busy_a[1] = busy1;
  assign busy_a[2] = busy2;

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
    .sck(sck), .rst(rst), .rx(rx_a[0]), .data_out(dout0), .data_valid(dv0),
    .parity_err(pe0), .frame_err(fe0), .busy(busy0));

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
    .sck(sck), .rst(rst), .rx(rx_a[1]), .data_out(dout1), .data_valid(dv1),
    .parity_err(pe1), .frame_err(fe1), .busy(busy1));

  uart_rx_os #(.DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(3)) u_9o2 (
    .sck(sck), .rst(rst), .rx(rx_a[2]), .data_out(dout2), .data_valid(dv2),
    .parity_err(pe2), .frame_err(fe2), .busy(busy2));

  function automatic int cfg_db(input int i); return (i == 2) ? 9 : 8; endfunction
  function automatic int cfg_pm(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int cfg_sb(input int i); return (i == 2) ? 2 : 1; endfunction
  function automatic int cfg_ss(input int i); return (i == 2) ? 3 : 2; endfunction

  // ---------------- scoreboard ----------------
  // entry: [44:43] instance, [42:11] strobe cycle, [10:2] data, [1] parity_err, [0] frame_err
  logic [44:0] exp_q[$];
  logic [10:0] held [3];      // {data, parity_err, frame_err} last strobed per instance
  int          strobes [3];
  int          last_strobe [3];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      held[i] = '0;
      strobes[i] = 0;
      last_strobe[i] = 0;
      rx_a[i] = 1'b1;
    end
  end

  // Compare process: every cycle, every instance.
  always @(negedge sck) begin
    logic [44:0] e;
    for (int i = 0; i < 3; i++) begin
      if (dv_a[i] === 1'b1) begin
        if (exp_q.size() == 0 || int'(exp_q[0][44:43]) != i) begin
          check($sformatf("inst%0d_unexpected_strobe", i), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("inst%0d_strobe_cycle", i), cyc, e[42:11]);
          check($sformatf("inst%0d_data", i), {23'd0, dout_a[i]}, {23'd0, e[10:2]});
          check($sformatf("inst%0d_parity_err", i), {31'd0, pe_a[i]}, {31'd0, e[1]});
          check($sformatf("inst%0d_frame_err", i), {31'd0, fe_a[i]}, {31'd0, e[0]});
          check($sformatf("inst%0d_busy_at_strobe", i), {31'd0, busy_a[i]}, 32'd0);
          held[i] = e[10:0];
          strobes[i]++;
          last_strobe[i] = cyc;
        end
      end else begin
        check($sformatf("inst%0d_hold", i), {21'd0, dout_a[i], pe_a[i], fe_a[i]}, {21'd0, held[i]});
        check($sformatf("inst%0d_valid_low", i), {31'd0, dv_a[i]}, 32'd0);
      end
    end
    if (exp_q.size() > 0 && exp_q[0][42:11] < cyc) begin
      e = exp_q.pop_front();
      check("missed_strobe", 32'd0, 32'd1);
    end
  end

  // ---------------- driver tasks (called #1 after a posedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge sck);
    #1;
  endtask

  task automatic drive_bit(input int i, input logic v);
    rx_a[i] = v;
    idle(CPB);
  endtask

  task automatic send_frame(input int i, input logic [8:0] data, input bit bad_par,
                            input logic [1:0] stop_vals, input bit keep_low);
    int db, pm, sb, ss, k, lat;
    logic [8:0] mask, d;
    logic x, p, exp_pe, exp_fe;
    db = cfg_db(i); pm = cfg_pm(i); sb = cfg_sb(i); ss = cfg_ss(i);
    mask = 9'((1 << db) - 1);
    d = data & mask;
    x = ^d;
    p = (pm == 1) ? ~x : x;
    if (bad_par) p = ~p;
    exp_pe = (pm != 0) && bad_par;
    exp_fe = (stop_vals[0] == 1'b0) || (sb == 2 && stop_vals[1] == 1'b0);
    // start detect after sync + 1, half bit to confirm start, one bit per later field, +1 to strobe
    lat = ss + CPB / 2 + CPB * (db + ((pm != 0) ? 1 : 0) + sb) + 2;
    k = cyc;
    exp_q.push_back({2'(i), 32'(k + lat), d, exp_pe, exp_fe});
    drive_bit(i, 1'b0);
    for (int b = 0; b < db; b++) drive_bit(i, d[b]);
    if (pm != 0) drive_bit(i, p);
    for (int s = 0; s < sb; s++) drive_bit(i, stop_vals[s]);
    if (!keep_low) rx_a[i] = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rx_a[i] = 1'b1;
    @(posedge sck);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) held[i] = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, k0, first;
    bit found;
    logic [1:0] sv;
    logic [8:0] d;

    // reset state
    idle(4);
    check("reset_dout0", {24'd0, dout0}, 32'd0);
    check("reset_dout2", {23'd0, dout2}, 32'd0);
    check("reset_flags", {26'd0, dv0, pe1, fe2, busy0, busy1, busy2}, 32'd0);
    rst = 1'b0;
    idle(CPB);

    // 1: 8N1 0xA5
    s0 = strobes[0];
    k0 = cyc;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
    idle(4);
    check("t1_one_strobe", strobes[0] - s0, 32'd1);
    check("t1_data", {24'd0, dout0}, 32'hA5);
    check("t1_flags", {30'd0, pe0, fe0}, 32'd0);
    check("t1_latency", last_strobe[0] - k0, 32'd156);

    // 2: even parity, 0x07 with wrong then right parity bit
    send_frame(1, 9'h007, 1'b1, 2'b11, 1'b0);
    idle(4);
    check("t2_data", {24'd0, dout1}, 32'h07);
    check("t2_parity_err", {31'd0, pe1}, 32'd1);
    send_frame(1, 9'h007, 1'b0, 2'b11, 1'b0);
    idle(4);
    check("t2_parity_ok", {31'd0, pe1}, 32'd0);

    // 3: 5-cycle glitch
    s0 = strobes[0];
    rx_a[0] = 1'b0;
    idle(5);
    check("t3_busy_in_glitch", {31'd0, busy0}, 32'd1);
    rx_a[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n <= 10 && !found; n++) begin
      if (!busy0) found = 1'b1;
      else idle(1);
    end
    check("t3_busy_returns", {31'd0, found}, 32'd1);
    idle(2 * CPB);
    check("t3_no_strobe", strobes[0] - s0, 32'd0);

    // 4: break after a bad stop, then recovery
    s0 = strobes[0];
    send_frame(0, 9'h03C, 1'b0, 2'b00, 1'b1);
    idle(30 * CPB);
    check("t4_one_strobe", strobes[0] - s0, 32'd1);
    check("t4_data", {24'd0, dout0}, 32'h3C);
    check("t4_frame_err", {31'd0, fe0}, 32'd1);
    rx_a[0] = 1'b1;
    idle(2 * CPB);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0);
    idle(4);
    check("t4_recover_data", {24'd0, dout0}, 32'h81);
    check("t4_recover_fe", {31'd0, fe0}, 32'd0);

    // 5: back-to-back 0x00, 0xFF
    send_frame(0, 9'h000, 1'b0, 2'b11, 1'b0);
    first = last_strobe[0];
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b0);
    idle(4);
    check("t5_spacing", last_strobe[0] - first, 32'd160);
    check("t5_data", {24'd0, dout0}, 32'hFF);

    // 6: reset during DATA bit 3 of a 9O2 frame, then 0x1AB
    s0 = strobes[2];
    d = 9'h155;
    drive_bit(2, 1'b0);
    for (int b = 0; b < 3; b++) drive_bit(2, d[b]);
    rx_a[2] = d[3];
    idle(8);
    check("t6_busy_mid_frame", {31'd0, busy2}, 32'd1);
    pulse_reset();
    check("t6_outputs_cleared", {20'd0, dout2, dv2, pe2, fe2}, 32'd0);
    check("t6_busy_cleared", {31'd0, busy2}, 32'd0);
    idle(20 * CPB);
    check("t6_no_strobe", strobes[2] - s0, 32'd0);
    send_frame(2, 9'h1AB, 1'b0, 2'b11, 1'b0);
    idle(4);
    check("t6_data", {23'd0, dout2}, 32'h1AB);
    check("t6_flags", {30'd0, pe2, fe2}, 32'd0);

    // random frames on random instances
    for (int n = 0; n < 60; n++) begin
      int i, gap;
      bit bad_par, last_bad;
      i = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        rx_a[i] = 1'b0;
        idle($urandom_range(1, 5));
        rx_a[i] = 1'b1;
        idle(CPB);
      end else begin
        d = 9'($urandom_range(0, 511));
        bad_par = (cfg_pm(i) != 0) && ($urandom_range(0, 3) == 0);
        sv = 2'b11;
        if ($urandom_range(0, 5) == 0) sv = 2'($urandom_range(0, 3));
        last_bad = (cfg_sb(i) == 1) ? !sv[0] : !sv[1];
        send_frame(i, d, bad_par, sv, 1'b0);
        gap = $urandom_range(0, 20);
        if (last_bad) gap += CPB;
        if (gap > 0) idle(gap);
      end
    end

    idle(4 * CPB);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
